// File: rtl/capture_readout.sv
// capture_readout: streams a window of the 8K x 8 capture BRAM to the host TX
// stream. It issues BRAM reads, absorbs the one-cycle read latency, and buffers
// bytes in a 2-entry FIFO that presents them on a valid/ready stream.
// Optional feature macro: READOUT_HEADER_EN. When it is defined, a 3-byte
// header (0xA5, LENGTH[13:8], LENGTH[7:0]) is sent before the data.
module capture_readout #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 14
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LENGTH,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic              RAM_EN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [DATA_W-1:0] RAM_DOUT,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_STREAM, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              in_flight_q, in_flight_d;
  logic [1:0]        count_q, count_d;
  logic              abort_done_q, abort_done_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
`ifdef READOUT_HEADER_EN
  logic [1:0]        hdr_idx_q, hdr_idx_d;
`endif

  logic              busy;
  logic              fifo_valid;
  logic              fifo_pop;
  logic              push;
  logic              rd;
  logic              abort_now;
  logic              drain_done;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_byte;
  logic [1:0]        occ;
  logic [1:0]        wr_slot;

`ifdef READOUT_HEADER_EN
  // Header byte selected by the sequencer index; length comes from the latched count.
  function automatic logic [DATA_W-1:0] hdr_byte(input logic [1:0] idx,
                                                 input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] b;
    case (idx)
      2'd0:    b = DATA_W'(8'hA5);
      2'd1:    b = DATA_W'(len >> 8);
      default: b = DATA_W'(len);
    endcase
    return b;
  endfunction
`endif

  // Next-state, read issue, FIFO bookkeeping and stream outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    count_d      = count_q;
    abort_done_d = 1'b0;
    fifo_d       = fifo_q;
`ifdef READOUT_HEADER_EN
    hdr_idx_d    = hdr_idx_q;
`endif

    busy       = (state_q != S_IDLE);
    fifo_valid = (count_q != 2'd0);
    tx_valid   = fifo_valid;
    tx_byte    = fifo_q[0];
`ifdef READOUT_HEADER_EN
    if (state_q == S_HDR) begin
      tx_valid = 1'b1;
      tx_byte  = hdr_byte(hdr_idx_q, remaining_q);
    end
`endif
    fifo_pop  = fifo_valid && TX_READY;
    push      = in_flight_q;
    abort_now = ABORT && busy;

    // A byte leaving this cycle frees its slot, which keeps 1 byte/cycle flow.
    occ = count_q + {1'b0, in_flight_q};
    rd  = (state_q == S_STREAM) && (remaining_q != '0) && !abort_now &&
          ((occ < 2'd2) || fifo_pop);

    drain_done = (state_q == S_DRAIN) && !fifo_valid && !in_flight_q;

    if (rd) begin
      addr_d      = addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
    in_flight_d = rd;

    // Shift on pop, then land the returning byte in the first free slot.
    wr_slot = count_q - {1'b0, fifo_pop};
    if (fifo_pop) fifo_d[0] = fifo_q[1];
    if (push) begin
      if (wr_slot == 2'd0) fifo_d[0] = RAM_DOUT;
      else                 fifo_d[1] = RAM_DOUT;
    end
    count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};

    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d      = START_ADDR;
          remaining_d = LENGTH;
`ifdef READOUT_HEADER_EN
          hdr_idx_d   = 2'd0;
          state_d     = S_HDR;
`else
          state_d     = S_STREAM;
`endif
        end
      end
`ifdef READOUT_HEADER_EN
      S_HDR: begin
        if (TX_READY) begin
          if (hdr_idx_q == 2'd2) state_d = S_STREAM;
          hdr_idx_d = hdr_idx_q + 2'd1;
        end
      end
`endif
      S_STREAM: begin
        if (remaining_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: flush, forget the in-flight read, report once.
    if (abort_now) begin
      state_d      = S_IDLE;
      count_d      = 2'd0;
      in_flight_d  = 1'b0;
      abort_done_d = !drain_done;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      in_flight_q  <= 1'b0;
      count_q      <= 2'd0;
      abort_done_q <= 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_idx_q    <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      in_flight_q  <= in_flight_d;
      count_q      <= count_d;
      abort_done_q <= abort_done_d;
`ifdef READOUT_HEADER_EN
      hdr_idx_q    <= hdr_idx_d;
`endif
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge CLK) begin
    fifo_q <= fifo_d;
  end

  assign BUSY     = busy;
  assign DONE     = drain_done || abort_done_q;
  assign RAM_EN   = rd;
  assign RAM_ADDR = addr_q;
  assign TX_VALID = tx_valid;
  assign TX_DATA  = tx_valid ? tx_byte : '0;

endmodule

// File: tb/tb_capture_readout.sv
// Testbench for capture_readout: BRAM model with one-cycle read latency, a
// randomized TX_READY source, and a reference model that predicts the byte
// stream directly from the start address, length and memory contents.
module tb_capture_readout;

`ifdef READOUT_HEADER_EN
  localparam int HN = 3;
`else
  localparam int HN = 0;
`endif

  logic        clk = 1'b0;
  logic        RSTN;
  logic        START;
  logic [12:0] START_ADDR;
  logic [13:0] LENGTH;
  logic        ABORT;
  logic        BUSY;
  logic        DONE;
  logic        RAM_EN;
  logic [12:0] RAM_ADDR;
  logic [7:0]  RAM_DOUT;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;

  logic [7:0]  mem [0:8191];

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [12:0] ralog[$];
  int first_valid, done_cyc, done_cnt, abort_cyc, busy_c1, busy_after;
  int stab_err, occ_err, ramen_err, hdr_rd_err, timed_out;
  logic valid_after_abort;

  capture_readout dut (
    .CLK(clk), .RSTN(RSTN), .START(START), .START_ADDR(START_ADDR),
    .LENGTH(LENGTH), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
    .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (RAM_EN) RAM_DOUT <= mem[RAM_ADDR];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mismatches between the first n received bytes and the predicted stream.
  function automatic int diff_prefix(input int n);
    int d = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) d++;
      else if (got_q[i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  // Run one transfer; rmode 0 = ready always high, 1 = random ready.
  // abort_at >= 0 raises ABORT after that many data handshakes.
  task automatic xfer(input int sa, input int len, input int rmode,
                      input int abort_at, input bit spur);
    int c, hs, rd, dhs;
    logic stall;
    logic [7:0] pdata;
    exp_q.delete(); got_q.delete(); ralog.delete();
`ifdef READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'((len >> 8) & 63));
    exp_q.push_back(8'(len & 255));
`endif
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(sa + i) % 8192]);
    first_valid = -1; done_cyc = -1; done_cnt = 0; abort_cyc = -1;
    busy_c1 = 0; busy_after = 1; valid_after_abort = 1'bx;
    stab_err = 0; occ_err = 0; ramen_err = 0; hdr_rd_err = 0; timed_out = 0;
    hs = 0; rd = 0; stall = 1'b0; pdata = 8'h00;

    @(posedge clk); #1;
    START = 1'b1; START_ADDR = 13'(sa); LENGTH = 14'(len);
    TX_READY = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    START = 1'b0;
    c = 0;
    while (1) begin
      c++;
      @(negedge clk);
      if (c == 1) busy_c1 = int'(BUSY);
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(BUSY);
      if (RAM_EN) begin
        rd++;
        ralog.push_back(RAM_ADDR);
        if (!BUSY) ramen_err++;
        if (hs < HN) hdr_rd_err++;
      end
      if (stall && !(abort_cyc >= 0 && c == abort_cyc + 1) &&
          (TX_VALID !== 1'b1 || TX_DATA !== pdata)) stab_err++;
      if (TX_VALID && first_valid < 0) first_valid = c;
      if (abort_cyc >= 0 && c == abort_cyc + 1) valid_after_abort = TX_VALID;
      if (TX_VALID && TX_READY) begin
        got_q.push_back(TX_DATA);
        hs++;
      end
      stall = TX_VALID && !TX_READY;
      pdata = TX_DATA;
      dhs = (hs > HN) ? hs - HN : 0;
      if (rd - dhs > 2) occ_err++;
      if (DONE) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      if (c > len * 8 + 60) begin timed_out = 1; break; end
      @(posedge clk); #1;
      ABORT = 1'b0;
      if (abort_at >= 0 && abort_cyc < 0 && hs == HN + abort_at) begin
        ABORT = 1'b1; abort_cyc = c + 1; TX_READY = 1'b0;
      end else begin
        TX_READY = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      START = spur && (c == 4);
      if (START) begin START_ADDR = 13'h0AAA; LENGTH = 14'd5; end
    end
    ABORT = 1'b0; START = 1'b0;
    chk("timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    int uniq, nz;
    bit seen [0:8191];
    logic [12:0] wrap_addr [4];

    RSTN = 1'b0; START = 1'b0; START_ADDR = '0; LENGTH = '0;
    ABORT = 1'b0; TX_READY = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 8'(a);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(BUSY), 32'd0);
    chk("rst_done",     32'(DONE), 32'd0);
    chk("rst_ram_en",   32'(RAM_EN), 32'd0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_tx_data",  32'(TX_DATA), 32'd0);
    @(posedge clk); #1 RSTN = 1'b1;

    // Basic: 0x0010, 4 bytes, ready high
    xfer(16'h0010, 4, 0, -1, 1'b0);
    chk("basic_count", 32'(got_q.size()), 32'(4 + HN));
    chk("basic_bytes", 32'(diff_prefix(4 + HN)), 32'd0);
    chk("basic_busy_c1", 32'(busy_c1), 32'd1);
    chk("basic_first_valid", 32'(first_valid), 32'((HN != 0) ? 1 : 3));
    chk("basic_done_cyc", 32'(done_cyc), 32'(7 + HN));
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_busy_after", 32'(busy_after), 32'd0);
    chk("basic_ramen_outside", 32'(ramen_err + hdr_rd_err), 32'd0);

    // Address wrap
    wrap_addr[0] = 13'h1FFE; wrap_addr[1] = 13'h1FFF;
    wrap_addr[2] = 13'h0000; wrap_addr[3] = 13'h0001;
    xfer(16'h1FFE, 4, 0, -1, 1'b0);
    chk("wrap_nreads", 32'(ralog.size()), 32'd4);
    nz = 0;
    for (int i = 0; i < 4 && i < ralog.size(); i++)
      if (ralog[i] !== wrap_addr[i]) nz++;
    chk("wrap_addr_seq", 32'(nz), 32'd0);
    chk("wrap_bytes", 32'(diff_prefix(4 + HN)), 32'd0);

    // Backpressure
    xfer(16'h0123, 16, 1, -1, 1'b0);
    chk("bp_count", 32'(got_q.size()), 32'(16 + HN));
    chk("bp_bytes", 32'(diff_prefix(16 + HN)), 32'd0);
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_outstanding", 32'(occ_err), 32'd0);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Abort after 5 data handshakes, then a clean short transfer
    xfer(16'h0100, 100, 1, 5, 1'b0);
    chk("abort_count", 32'(got_q.size()), 32'(5 + HN));
    chk("abort_bytes", 32'(diff_prefix(5 + HN)), 32'd0);
    chk("abort_valid_low", 32'(valid_after_abort), 32'd0);
    chk("abort_done_cyc", 32'(done_cyc), 32'(abort_cyc + 1));
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    xfer(16'h0200, 2, 1, -1, 1'b0);
    chk("post_abort_count", 32'(got_q.size()), 32'(2 + HN));
    chk("post_abort_bytes", 32'(diff_prefix(2 + HN)), 32'd0);
    chk("post_abort_done_cnt", 32'(done_cnt), 32'd1);

    // ABORT while idle does nothing
    @(posedge clk); #1 ABORT = 1'b1;
    @(posedge clk); #1 ABORT = 1'b0;
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (DONE !== 1'b0 || BUSY !== 1'b0) nz++;
    end
    chk("idle_abort_quiet", 32'(nz), 32'd0);

    // LENGTH = 0
    xfer(16'h0055, 0, 0, -1, 1'b0);
    chk("len0_nreads", 32'(ralog.size()), 32'd0);
    chk("len0_count", 32'(got_q.size()), 32'(HN));
    chk("len0_bytes", 32'(diff_prefix(HN)), 32'd0);
    chk("len0_done_cyc", 32'(done_cyc), 32'(2 + HN));

    // Full memory with a START pulse during BUSY
    xfer(16'h0000, 8192, 0, -1, 1'b1);
    chk("full_count", 32'(got_q.size()), 32'(8192 + HN));
    chk("full_bytes", 32'(diff_prefix(8192 + HN)), 32'd0);
    chk("full_nreads", 32'(ralog.size()), 32'd8192);
    for (int a = 0; a < 8192; a++) seen[a] = 1'b0;
    uniq = 0;
    foreach (ralog[i]) begin
      if (!seen[ralog[i]]) uniq++;
      seen[ralog[i]] = 1'b1;
    end
    chk("full_unique_addr", 32'(uniq), 32'd8192);
    chk("full_done_cyc", 32'(done_cyc), 32'(8192 + 3 + HN));
    chk("full_done_cnt", 32'(done_cnt), 32'd1);

    // Random memory, random windows, random backpressure
    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      int sa, ln;
      sa = int'($urandom_range(0, 8191));
      ln = int'($urandom_range(1, 40));
      xfer(sa, ln, 1, -1, 1'b0);
      chk("rand_count", 32'(got_q.size()), 32'(ln + HN));
      chk("rand_bytes", 32'(diff_prefix(ln + HN)), 32'd0);
      chk("rand_rules", 32'(stab_err + occ_err + ramen_err + hdr_rd_err), 32'd0);
      chk("rand_done_cnt", 32'(done_cnt), 32'd1);
    end

    // Reset in the middle of a transfer
    @(posedge clk); #1;
    START = 1'b1; START_ADDR = 13'h0400; LENGTH = 14'd20; TX_READY = 1'b1;
    @(posedge clk); #1 START = 1'b0;
    repeat (6) @(posedge clk);
    #1 RSTN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", {22'd0, BUSY, DONE, RAM_EN, TX_VALID, RAM_ADDR == 13'd0 ? 1'b0 : 1'b1,
                           TX_DATA == 8'd0 ? 1'b0 : 1'b1, 4'd0}, 32'd0);
    @(posedge clk); #1 RSTN = 1'b1;
    nz = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (DONE !== 1'b0 || BUSY !== 1'b0 || TX_VALID !== 1'b0) nz++;
    end
    chk("midrst_no_done", 32'(nz), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
